// File: rtl/spike_rx_conditioner.sv
// Spike line receiver: synchroniser, edge detect, per-channel refractory FSM, windowed counts.
// Optional glitch filter: define SPIKE_RX_GLITCH_FILTER_EN.
module spike_rx_conditioner #(
  parameter int unsigned NCH         = 14,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned REFRAC_W    = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       spike_raw,
  input  logic [NCH-1:0]       enable_mask,
  input  logic [REFRAC_W-1:0]  refrac_cycles,
  input  logic                 sim_tick,
  output logic [NCH-1:0]       spike_out,
  output logic [NCH*CNT_W-1:0] spike_count_flat,
  output logic                 count_valid,
  output logic [NCH-1:0]       overflow,
  output logic [NCH-1:0]       dropped
);

  typedef enum logic {IDLE, REFRAC} state_t;

`ifdef SPIKE_RX_GLITCH_FILTER_EN
  localparam int unsigned LAT = SYNC_STAGES + 1;
`else
  localparam int unsigned LAT = SYNC_STAGES;
`endif
  localparam int unsigned       WARM_W    = $clog2(LAT + 1);
  localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(LAT);

  logic [NCH-1:0]    sync_q [SYNC_STAGES];
  logic [NCH-1:0]    sync_out;
  logic [NCH-1:0]    level;
  logic [NCH-1:0]    prev_q, prev_d;
  logic [NCH-1:0]    edge_det;
  logic [WARM_W-1:0] warm_q;

  state_t            state_q [NCH];
  state_t            state_d [NCH];
  logic [REFRAC_W-1:0] rcnt_q [NCH];
  logic [REFRAC_W-1:0] rcnt_d [NCH];
  logic [NCH-1:0]    accept, drop_set;

  logic [CNT_W-1:0]  cnt_q   [NCH];
  logic [CNT_W-1:0]  cnt_d   [NCH];
  logic [CNT_W-1:0]  cnt_inc [NCH];
  logic [NCH-1:0]    ovf_q, ovf_d, ovf_inc;

  logic [NCH-1:0]       spike_out_q, dropped_q, overflow_q;
  logic [NCH*CNT_W-1:0] flat_q, flat_d;
  logic                 count_valid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= spike_raw;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef SPIKE_RX_GLITCH_FILTER_EN
  logic [NCH-1:0] sdly_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sdly_q <= '0;
    else        sdly_q <= sync_out;
  end
  assign level = sync_out & sdly_q;
`else
  assign level = sync_out;
`endif

  // prev stays preset until the pipeline holds real samples, so a line
  // already high at reset release never looks like a rising edge.
  assign prev_d   = (warm_q == WARM_DONE) ? level : '1;
  assign edge_det = level & ~prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      warm_q <= '0;
      prev_q <= '1;
    end else begin
      if (warm_q != WARM_DONE) warm_q <= warm_q + 1'b1;
      prev_q <= prev_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      state_d[i]  = state_q[i];
      rcnt_d[i]   = rcnt_q[i];
      accept[i]   = 1'b0;
      drop_set[i] = 1'b0;
      if (!enable_mask[i]) begin
        state_d[i] = IDLE;
        rcnt_d[i]  = '0;
      end else begin
        case (state_q[i])
          IDLE: begin
            if (edge_det[i]) begin
              accept[i]  = 1'b1;
              rcnt_d[i]  = refrac_cycles;
              state_d[i] = (refrac_cycles != '0) ? REFRAC : IDLE;
            end
          end
          REFRAC: begin
            drop_set[i] = edge_det[i];
            if (rcnt_q[i] != '0) rcnt_d[i] = rcnt_q[i] - 1'b1;
            if (rcnt_q[i] <= REFRAC_W'(1)) state_d[i] = IDLE;
          end
          default: state_d[i] = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    flat_d = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      cnt_inc[i] = (accept[i] && (cnt_q[i] != '1)) ? cnt_q[i] + 1'b1 : cnt_q[i];
      ovf_inc[i] = ovf_q[i] | (accept[i] & (cnt_q[i] == '1));
      flat_d[i*CNT_W +: CNT_W] = cnt_inc[i];
      cnt_d[i]   = sim_tick ? '0 : cnt_inc[i];
      ovf_d[i]   = sim_tick ? 1'b0 : ovf_inc[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        state_q[i] <= IDLE;
        rcnt_q[i]  <= '0;
        cnt_q[i]   <= '0;
      end
      ovf_q         <= '0;
      spike_out_q   <= '0;
      dropped_q     <= '0;
      overflow_q    <= '0;
      flat_q        <= '0;
      count_valid_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        rcnt_q[i]  <= rcnt_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      ovf_q         <= ovf_d;
      spike_out_q   <= accept;
      dropped_q     <= dropped_q | drop_set;
      count_valid_q <= sim_tick;
      if (sim_tick) begin
        flat_q     <= flat_d;
        overflow_q <= ovf_inc;
      end
    end
  end

  assign spike_out        = spike_out_q;
  assign dropped          = dropped_q;
  assign overflow         = overflow_q;
  assign spike_count_flat = flat_q;
  assign count_valid      = count_valid_q;

endmodule

// File: doc/spike_rx_conditioner.md
Name: spike_rx_conditioner

Overview:
Front-end for spike lines arriving from other rack boards. Raw inputs are asynchronous to neuron_clk; they feed synapse spike_in ports and per-window rate readout.
- Synchronises each line, detects rising edges and emits one-cycle spike pulses.
- Enforces a programmable per-channel refractory period and masks channels.
- Counts accepted spikes per simulation window (sim_tick) for OpalKelly readout.

Parameters:
NCH, 14, number of spike channels
SYNC_STAGES, 2, synchroniser flops per channel (min 2)
REFRAC_W, 8, width of refractory cycle count
CNT_W, 16, width of per-channel window spike counter

Ports:
clk  in  1  neuron_clk domain clock; single clock for the whole block
reset  in  1  asynchronous, active-low reset (0 = reset)
spike_raw  in  NCH  asynchronous raw spike lines from rack connectors
enable_mask  in  NCH  1 = channel enabled
refrac_cycles  in  REFRAC_W  refractory length in clk cycles, shared by all channels
sim_tick  in  1  one-cycle strobe (clk domain) marking the end of a simulation window
spike_out  out  NCH  one-cycle pulse per accepted spike, to synapse spike_in
spike_count_flat  out  NCH*CNT_W  latched window counts; channel i at [i*CNT_W +: CNT_W]
count_valid  out  1  one-cycle pulse: spike_count_flat updated
overflow  out  NCH  channel counter saturated in the latched window
dropped  out  NCH  sticky: edge arrived during refractory; cleared only by reset

Behaviour:
- Reset (reset=0, async):
  - Sync flops = 0; edge-history register prev = 1 (preset). A line already high at reset release produces no spike.
  - Refractory counters, window counters, spike_out, spike_count_flat, count_valid, overflow and dropped all = 0.
- Edge detect:
  - edge[i] = sync_out[i] & ~prev[i]; prev[i] <= sync_out[i] every cycle.
  - The synchroniser runs regardless of enable_mask.
- Per-channel FSM, states IDLE and REFRAC:
  - IDLE, edge & enable: spike_out[i] <= 1 for exactly one cycle. Load rcnt <= refrac_cycles. Go to REFRAC if refrac_cycles != 0, else stay IDLE.
  - REFRAC: rcnt decrements each cycle; return to IDLE in the cycle rcnt reaches 0 (rcnt==1 -> IDLE).
  - REFRAC, edge: the edge is dropped and dropped[i] <= 1.
  - enable_mask[i]=0: force IDLE, rcnt <= 0, no spike_out, no count. Edges while disabled are ignored and do not set dropped.
  - refrac_cycles changed mid-refractory: the new value applies only at the next load.
- Latency: counting the first clk edge that samples spike_raw high as edge 1, spike_out is high after edge SYNC_STAGES+1 (edge 3 for default) and low after the next edge.
- Window counting:
  - Each accepted spike increments cnt[i], saturating at 2^CNT_W-1.
  - An increment attempted at saturation sets a per-window ovf flag.
- On sim_tick:
  - spike_count_flat <= cnt (including a spike accepted in the same cycle) and overflow <= ovf, registered.
  - count_valid = 1 in the following cycle only.
  - cnt and ovf are cleared in that same edge.
  - A spike accepted in the sim_tick cycle counts in the closing window; the new window starts at 0.
- Back-to-back sim_tick in consecutive cycles: the second latches only spikes accepted in between (possibly 0).
- Minimum accepted spacing with refrac_cycles=0: 2 cycles, since the raw line must fall and rise again.
- Width rules: counters are unsigned; rcnt is never negative (no decrement at 0).

Optional Feature:
SPIKE_RX_GLITCH_FILTER_EN:
- Defined: one extra register stage. A level is accepted only when two consecutive synchronised samples agree (filtered = s & s_d; falls when s & s_d == 0). Single-cycle synchronised pulses are rejected. Latency grows by 1 (spike_out after edge SYNC_STAGES+2).
- Undefined: no filter; latency as above.

Test Plan:
1. Reset release with spike_raw[0] held high and all enabled -> no spike_out for 20 cycles; prev settles high.
2. refrac_cycles=0, spike_raw[3] rises at edge 1 and is held 5 cycles -> spike_out[3] high exactly one cycle, after edge 3; count 1 at next sim_tick, count_valid pulse one cycle later.
3. refrac_cycles=10, three rising edges on ch5 spaced 4 cycles apart -> one spike_out; dropped[5]=1; then an edge 12 cycles after the first -> second spike_out.
4. CNT_W=4 build, 20 accepted spikes on ch0 within one window -> spike_count_flat[3:0]=15, overflow[0]=1; next window with 2 spikes -> 2, overflow[0]=0.
5. Spike accepted in the same cycle as sim_tick -> counted in the closing window; new window reads 0 if idle; enable_mask[7]=0 during a burst -> spike_out[7]=0, count 0, dropped[7]=0.
6. Reset asserted mid-refractory and mid-window -> all outputs 0 immediately; with SPIKE_RX_GLITCH_FILTER_EN, a 1-cycle raw pulse -> no spike, a 3-cycle pulse -> one spike after edge 4.
